// File: rtl/tank_pump_ctrl.sv
// Water-tank pump controller: debounces the level and sensor-fault flags and
// runs a hysteresis fill FSM with a latched alarm that the operator acknowledges.
module tank_pump_ctrl #(
  parameter int DEB_CYCLES   = 4,
  parameter int FILL_TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] C,
  input  logic [1:0] Pout,
  input  logic       ack,
  output logic       pump,
  output logic [1:0] alarm,
  output logic       fill_done,
  output logic [1:0] state_o
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam int TW = $clog2(FILL_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(FILL_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FILL  = 2'b01,
    FULL  = 2'b10,
    FAULT = 2'b11
  } state_t;

  logic [3:0]    rawIn;
  logic [3:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    lv_q, lv_d;
  logic [1:0]    flt_q, flt_d;

  state_t        state_q;
  logic [1:0]    alarm_q;
  logic          fill_done_q;
  logic [TW-1:0] timer_q;

  logic          sensFault;
  logic          levelFault;
  logic [1:0]    faultCode;

  assign rawIn = {Pout, C};

  // A raw value is accepted only after it has been seen unchanged for
  // DEB_CYCLES consecutive edges following the edge that first captured it.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    lv_d   = lv_q;
    flt_d  = flt_q;
    if (rawIn != cand_q) begin
      cand_d = rawIn;
      cnt_d  = '0;
    end else if (cnt_q == CNT_LAST) begin
      {flt_d, lv_d} = cand_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cand_q <= 4'b0001;
      cnt_q  <= '0;
      lv_q   <= 2'b01;
      flt_q  <= 2'b00;
    end else begin
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
      lv_q   <= lv_d;
      flt_q  <= flt_d;
    end
  end

  assign sensFault  = (flt_q != 2'b00);
  assign levelFault = (lv_q == 2'b10);
  assign faultCode  = sensFault ? 2'b01 : 2'b10;

  // Fill completion is tested before the timeout so that a tank reaching
  // full on the last allowed cycle is not reported as a fault.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      alarm_q     <= 2'b00;
      fill_done_q <= 1'b0;
      timer_q     <= '0;
    end else begin
      fill_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sensFault || levelFault) begin
            state_q <= FAULT;
            alarm_q <= faultCode;
          end else if (lv_q == 2'b00) begin
            state_q <= FILL;
            timer_q <= '0;
          end
        end
        FILL: begin
          if (sensFault || levelFault) begin
            state_q <= FAULT;
            alarm_q <= faultCode;
          end else if (lv_q == 2'b11) begin
            state_q     <= FULL;
            fill_done_q <= 1'b1;
          end else if (timer_q == TMR_LAST) begin
            state_q <= FAULT;
            alarm_q <= 2'b11;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        FULL: begin
          if (sensFault || levelFault) begin
            state_q <= FAULT;
            alarm_q <= faultCode;
          end else if (lv_q == 2'b00) begin
            state_q <= FILL;
            timer_q <= '0;
          end
        end
        FAULT: begin
          if (ack && !sensFault && !levelFault) begin
            state_q <= IDLE;
            alarm_q <= 2'b00;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pump      = (state_q == FILL);
  assign alarm     = alarm_q;
  assign fill_done = fill_done_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_tank_pump_ctrl.sv
// Directed plus randomized bench for tank_pump_ctrl, checked every cycle
// against a behavioural model built from run lengths and fill-cycle counts.
module tb_tank_pump_ctrl;

  localparam int DEB = 4;
  localparam int FT  = 20;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       ack   = 1'b0;
  logic [1:0] C     = 2'b01;
  logic [1:0] Pout  = 2'b00;
  logic       pump;
  logic       fill_done;
  logic [1:0] alarm;
  logic [1:0] state_o;

  int checks = 0;
  int errors = 0;

  int         mState;
  int         mAlarm;
  int         mFillDone;
  int         mLv;
  int         mFlt;
  int         mFillCycles;
  int         mRun;
  logic [3:0] mHeld;

  tank_pump_ctrl #(
    .DEB_CYCLES  (DEB),
    .FILL_TIMEOUT(FT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .C        (C),
    .Pout     (Pout),
    .ack      (ack),
    .pump     (pump),
    .alarm    (alarm),
    .fill_done(fill_done),
    .state_o  (state_o)
  );

  always #5 clk = ~clk;

  // Model: a raw value counts as filtered once it has been present on
  // DEB+1 consecutive edges; the fill timeout is a count of FILL cycles.
  task automatic modelEdge();
    int  nextFd;
    bit  sens;
    bit  lvl;
    int  code;
    if (reset) begin
      mState = 0; mAlarm = 0; mFillDone = 0;
      mLv = 1; mFlt = 0; mFillCycles = 0;
      mHeld = 4'b0001; mRun = 1;
      return;
    end
    nextFd = 0;
    sens = (mFlt != 0);
    lvl  = (mLv == 2);
    code = sens ? 1 : 2;
    case (mState)
      0: begin
        if (sens || lvl) begin mState = 3; mAlarm = code; end
        else if (mLv == 0) begin mState = 1; mFillCycles = 1; end
      end
      1: begin
        if (sens || lvl) begin mState = 3; mAlarm = code; end
        else if (mLv == 3) begin mState = 2; nextFd = 1; end
        else if (mFillCycles == FT) begin mState = 3; mAlarm = 3; end
        else mFillCycles++;
      end
      2: begin
        if (sens || lvl) begin mState = 3; mAlarm = code; end
        else if (mLv == 0) begin mState = 1; mFillCycles = 1; end
      end
      default: begin
        if (ack && !sens && !lvl) begin mState = 0; mAlarm = 0; end
      end
    endcase
    mFillDone = nextFd;
    if ({Pout, C} == mHeld) begin
      if (mRun < 1000) mRun++;
    end else begin
      mHeld = {Pout, C};
      mRun  = 1;
    end
    if (mRun >= DEB + 1) begin
      mLv  = int'(mHeld[1:0]);
      mFlt = int'(mHeld[3:2]);
    end
  endtask

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic checkOutput();
    checkVal("state_o", {30'd0, state_o}, mState);
    checkVal("pump", {31'd0, pump}, (mState == 1) ? 1 : 0);
    checkVal("alarm", {30'd0, alarm}, mAlarm);
    checkVal("fill_done", {31'd0, fill_done}, mFillDone);
  endtask

  task automatic applyStimulus(input logic [1:0] cIn, input logic [1:0] pIn,
                               input logic aIn, input logic rIn, input int n);
    C = cIn; Pout = pIn; ack = aIn; reset = rIn;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      modelEdge();
      #1;
      checkOutput();
    end
  endtask

  initial begin
    int         r;
    int         hold;
    logic [1:0] cNew;
    logic [1:0] pNew;
    logic       aNew;
    logic       rNew;

    $display("[TB] start DEB=%0d FT=%0d", DEB, FT);

    applyStimulus(2'b01, 2'b00, 1'b0, 1'b1, 2);
    applyStimulus(2'b01, 2'b00, 1'b0, 1'b0, 50);
    checkVal("t1_state", {30'd0, state_o}, 0);
    checkVal("t1_alarm", {30'd0, alarm}, 0);

    applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 5);
    checkVal("t2_fill_early", {30'd0, state_o}, 0);
    applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 1);
    checkVal("t2_fill_state", {30'd0, state_o}, 1);
    checkVal("t2_fill_pump", {31'd0, pump}, 1);
    applyStimulus(2'b11, 2'b00, 1'b0, 1'b0, 5);
    checkVal("t2_full_early", {30'd0, state_o}, 1);
    applyStimulus(2'b11, 2'b00, 1'b0, 1'b0, 1);
    checkVal("t2_full_state", {30'd0, state_o}, 2);
    checkVal("t2_full_pump", {31'd0, pump}, 0);
    checkVal("t2_done_pulse", {31'd0, fill_done}, 1);
    applyStimulus(2'b11, 2'b00, 1'b0, 1'b0, 1);
    checkVal("t2_done_drop", {31'd0, fill_done}, 0);
    applyStimulus(2'b01, 2'b00, 1'b0, 1'b0, 10);
    checkVal("t2_hyst_full", {30'd0, state_o}, 2);

    applyStimulus(2'b01, 2'b00, 1'b0, 1'b1, 2);
    applyStimulus(2'b01, 2'b00, 1'b0, 1'b0, 3);
    applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 3);
    applyStimulus(2'b01, 2'b00, 1'b0, 1'b0, 10);
    checkVal("t3_glitch_state", {30'd0, state_o}, 0);
    checkVal("t3_glitch_pump", {31'd0, pump}, 0);

    applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 25);
    checkVal("t4_last_fill", {30'd0, state_o}, 1);
    applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 1);
    checkVal("t4_timeout_state", {30'd0, state_o}, 3);
    checkVal("t4_timeout_alarm", {30'd0, alarm}, 3);
    checkVal("t4_timeout_pump", {31'd0, pump}, 0);
    applyStimulus(2'b00, 2'b00, 1'b1, 1'b0, 1);
    checkVal("t4_ack_idle", {30'd0, state_o}, 0);
    checkVal("t4_ack_alarm", {30'd0, alarm}, 0);
    applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 1);
    checkVal("t4_refill", {30'd0, state_o}, 1);

    applyStimulus(2'b00, 2'b01, 1'b0, 1'b0, 5);
    checkVal("t5_sens_early", {30'd0, state_o}, 1);
    applyStimulus(2'b00, 2'b01, 1'b0, 1'b0, 1);
    checkVal("t5_sens_alarm", {30'd0, alarm}, 1);
    applyStimulus(2'b00, 2'b01, 1'b1, 1'b0, 3);
    checkVal("t5_ack_ignored", {30'd0, state_o}, 3);
    applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 6);
    checkVal("t5_still_fault", {30'd0, state_o}, 3);
    applyStimulus(2'b00, 2'b00, 1'b1, 1'b0, 1);
    checkVal("t5_clear_state", {30'd0, state_o}, 0);
    checkVal("t5_clear_alarm", {30'd0, alarm}, 0);

    applyStimulus(2'b10, 2'b00, 1'b0, 1'b0, 6);
    checkVal("t6_level_alarm", {30'd0, alarm}, 2);
    applyStimulus(2'b10, 2'b10, 1'b0, 1'b1, 1);
    applyStimulus(2'b10, 2'b10, 1'b0, 1'b0, 6);
    checkVal("t6_prio_alarm", {30'd0, alarm}, 1);
    applyStimulus(2'b10, 2'b10, 1'b1, 1'b1, 1);
    checkVal("t6_rst_state", {30'd0, state_o}, 0);
    checkVal("t6_rst_alarm", {30'd0, alarm}, 0);
    checkVal("t6_rst_pump", {31'd0, pump}, 0);

    applyStimulus(2'b01, 2'b00, 1'b0, 1'b1, 2);
    for (int seg = 0; seg < 150; seg++) begin
      r = $urandom_range(0, 99);
      if (r < 35)      cNew = 2'b00;
      else if (r < 65) cNew = 2'b11;
      else if (r < 92) cNew = 2'b01;
      else             cNew = 2'b10;
      pNew = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      aNew = ($urandom_range(0, 3) == 0);
      rNew = ($urandom_range(0, 49) == 0);
      hold = rNew ? 1 : $urandom_range(1, 30);
      applyStimulus(cNew, pNew, aNew, rNew, hold);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tank_pump_ctrl.md
Name: tank_pump_ctrl

Overview:
- Consumer side of the water-level sensing FSM.
- Takes its level flags C[1:0] and sensor-error flags Pout[1:0], debounces both, and runs a hysteresis fill controller that drives the pump.
- Latches an alarm code on sensor error, inconsistent level, or fill timeout; the operator clears it with ack.
- Sits between the level FSM and the pump driver / status panel.

Parameters:
- DEB_CYCLES, 4, consecutive stable cycles required before a raw C/Pout value is accepted (>=1).
- FILL_TIMEOUT, 1000, maximum cycles allowed in FILL before a timeout fault (>=2).

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- C  input  2  level flags: C[0]=low sensor wet, C[1]=high sensor wet
- Pout  input  2  sensor error flags, nonzero = fault
- ack  input  1  operator fault acknowledge, level-sampled
- pump  output  1  pump enable
- alarm  output  2  latched fault code: 00 none, 01 sensor error, 10 inconsistent level, 11 fill timeout
- fill_done  output  1  one-cycle pulse when a fill completes
- state_o  output  2  current state: 00 IDLE, 01 FILL, 10 FULL, 11 FAULT

Behaviour:
- Reset is synchronous, active-high, and overrides everything, including ack.
- Reset values:
  - state IDLE; pump 0; alarm 00; fill_done 0.
  - Filtered level lv = 01; filtered fault flt = 00.
  - Debounce candidate = {C=01, Pout=00}; debounce count 0; fill timer 0.
- Debounce operates on the 4-bit vector {Pout, C}:
  - Input differs from candidate: candidate <= input, count <= 0.
  - Else, count == DEB_CYCLES-1: {flt, lv} <= candidate.
  - Else: count increments.
  - A change held stable first appears on lv/flt DEB_CYCLES+1 cycles after it arrives.
  - A glitch shorter than DEB_CYCLES+1 cycles never propagates.
- Fault conditions, evaluated on filtered values only:
  - Priority: flt != 00 (code 01) > lv == 10, high wet with low dry (code 10) > timeout (code 11).
- FSM:
  - IDLE:
    - Any fault condition -> FAULT with the corresponding code.
    - Else lv == 00 -> FILL.
    - Else stay.
  - FILL:
    - Timer clears on entry and increments each cycle in FILL.
    - Fault condition -> FAULT.
    - Else lv == 11 -> FULL, with fill_done = 1 in the first FULL cycle.
    - Else timer == FILL_TIMEOUT-1 -> FAULT, code 11.
    - lv == 11 on the same cycle as timer expiry -> FULL; completion wins.
    - lv == 01 keeps filling (hysteresis).
  - FULL:
    - Fault condition -> FAULT.
    - Else lv == 00 -> FILL.
    - Else stay; lv 01 or 11 holds the pump off.
  - FAULT:
    - pump = 0; alarm holds the code captured on entry.
    - ack = 1 with flt == 00 and lv != 10 -> IDLE, alarm <= 00.
    - ack while a sensor or level condition is still active is ignored.
    - A timeout fault clears on ack alone once the filtered inputs are clean.
- Outputs:
  - pump = 1 exactly when state is FILL, decoded from the state register with no extra latency.
  - state_o mirrors state.
  - fill_done is never high for more than one cycle; it is low in all other cycles.
- Timer width is clog2(FILL_TIMEOUT); the timer does not wrap, because FAULT is entered at FILL_TIMEOUT-1.
- Mid-fill reset: pump drops on the cycle after the reset edge, the alarm clears, and the debounce restarts from its reset candidate.

Test Plan (DEB_CYCLES=4, FILL_TIMEOUT=20):
1. Reset with C=01, Pout=00, held 50 cycles -> pump 0, alarm 00, state_o 00 throughout.
2. C 01->00 held -> state_o 01 and pump 1 exactly 6 cycles after the change. Then C=11 -> state_o 10 and pump 0 6 cycles later, with fill_done high for exactly 1 cycle. Then C=01 -> stays FULL.
3. From IDLE, C=00 for 3 cycles, then back to 01 -> pump never asserts; lv stays 01.
4. C=00 held, never 11 -> after 20 FILL cycles, state_o 11, alarm 11, pump 0. Then ack=1 for 1 cycle with C=00 -> IDLE, then FILL again.
5. During FILL, Pout=01 -> FAULT with alarm 01 within 6 cycles. ack while Pout=01 is ignored. Pout=00 held 5+ cycles, then ack -> IDLE, alarm 00.
6. C=10 held -> alarm 10. C=10 with Pout=10 together -> alarm 01. reset=1 with ack=1 in FAULT -> all outputs at reset values next cycle.
